// File: rtl/dii_package.sv
// Shared DII link types.
//   dii_flit          : one flit on a DII link (valid, last, data)
//   dii_flit_assemble : builds a dii_flit from its fields
//   arb_state_e       : packet arbiter state, reusable by multi-port blocks
package dii_package;

  localparam int unsigned DII_DATA_WIDTH = 16;

  typedef struct packed {
    logic                      valid;
    logic                      last;
    logic [DII_DATA_WIDTH-1:0] data;
  } dii_flit;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_e;

  function automatic dii_flit dii_flit_assemble(input logic                      valid,
                                                input logic                      last,
                                                input logic [DII_DATA_WIDTH-1:0] data);
    dii_flit f;
    f.valid = valid;
    f.last  = last;
    f.data  = data;
    return f;
  endfunction

endpackage

// File: rtl/dii_rr_select.sv
// Combinational round-robin first-one finder.
//   req    : per-port request vector
//   rr_ptr : index with highest priority this round
//   idx    : first requesting index at or after rr_ptr, wrapping modulo PORTS
//   any    : at least one request is set
module dii_rr_select #(
  parameter int unsigned PORTS = 2,
  parameter int unsigned IDW   = 1
) (
  input  logic [PORTS-1:0] req,
  input  logic [IDW-1:0]   rr_ptr,
  output logic [IDW-1:0]   idx,
  output logic             any
);

  int unsigned    sum;
  logic [IDW-1:0] cand;

  always_comb begin
    idx  = '0;
    any  = 1'b0;
    sum  = 0;
    cand = '0;
    for (int unsigned k = 0; k < PORTS; k++) begin
      sum  = 32'(rr_ptr) + k;
      cand = IDW'((sum >= PORTS) ? sum - PORTS : sum);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/dii_packet_arbiter.sv
// Round-robin packet arbiter merging PORTS DII flit streams onto one link.
// A grant is held from the first flit through the flit carrying last.
//   clk, rst       : clock, asynchronous active-high reset
//   packet_size    : per-port buffered complete-packet length (FULLPACKET != 0)
//   flit_in        : upstream flits
//   flit_in_ready  : per-port ready, only the granted port can be ready
//   flit_out       : registered downstream flit
//   flit_out_ready : downstream ready
//   grant_id       : currently or last granted port
//   busy           : a packet is locked
module dii_packet_arbiter
  import dii_package::*;
#(
  parameter int unsigned  PORTS      = 2,
  parameter int unsigned  BUF_SIZE   = 4,
  parameter int unsigned  FULLPACKET = 1,
  localparam int unsigned IDW        = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [PORTS-1:0][$clog2(BUF_SIZE):0] packet_size,
  input  dii_flit [PORTS-1:0]                 flit_in,
  output logic [PORTS-1:0]                    flit_in_ready,
  output dii_flit                             flit_out,
  input  logic                                flit_out_ready,
  output logic [IDW-1:0]                      grant_id,
  output logic                                busy
);

  arb_state_e                state;
  logic [IDW-1:0]            rr_ptr;
  logic [IDW-1:0]            sel;
  logic [IDW-1:0]            sel_next;
  logic [IDW-1:0]            ptr_after;
  logic                      out_valid;
  logic                      out_last;
  logic [DII_DATA_WIDTH-1:0] out_data;
  logic [PORTS-1:0]          req;
  logic                      any_req;
  logic                      in_ready;
  logic                      fire;
  dii_flit                   cur;

  always_comb begin
    req = '0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      req[i] = flit_in[i].valid && ((FULLPACKET == 0) || (packet_size[i] != '0));
    end
  end

  dii_rr_select #(
    .PORTS (PORTS),
    .IDW   (IDW)
  ) u_rr_select (
    .req    (req),
    .rr_ptr (rr_ptr),
    .idx    (sel_next),
    .any    (any_req)
  );

  // Pass-through ready: the output register accepts a new flit in the same
  // cycle the downstream takes the current one.
  assign cur       = flit_in[sel];
  assign in_ready  = !out_valid || flit_out_ready;
  assign fire      = (state == ARB_LOCKED) && in_ready && cur.valid;
  assign ptr_after = (sel == IDW'(PORTS - 1)) ? '0 : sel + 1'b1;

  always_comb begin
    flit_in_ready = '0;
    if (state == ARB_LOCKED) begin
      flit_in_ready[sel] = in_ready;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ARB_IDLE;
      rr_ptr    <= '0;
      sel       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      // The output register drains in either state so the last flit of a
      // packet is not repeated while arbitrating for the next one.
      if (fire) begin
        out_valid <= 1'b1;
        out_last  <= cur.last;
        out_data  <= cur.data;
      end else if (flit_out_ready) begin
        out_valid <= 1'b0;
      end

      unique case (state)
        ARB_IDLE: begin
          if (any_req) begin
            sel   <= sel_next;
            state <= ARB_LOCKED;
          end
        end
        ARB_LOCKED: begin
          if (fire && cur.last) begin
            state  <= ARB_IDLE;
            rr_ptr <= ptr_after;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign flit_out = dii_flit_assemble(out_valid, out_last, out_data);
  assign grant_id = sel;
  assign busy     = (state == ARB_LOCKED);

endmodule

// File: doc/dii_packet_arbiter.md
# dii_packet_arbiter

Round-robin packet arbiter that merges `PORTS` upstream DII flit streams, each normally the output of a `dii_buffer` instance, onto one downstream DII link. A grant is held for a whole packet, from the first flit through the flit with `last`, so packets never interleave. With `FULLPACKET` set, a port is eligible only when its buffer reports a complete packet (`packet_size != 0`), so a granted packet streams without upstream stalls. The block sits between the per-source packet buffers and the shared debug interconnect port.

## Interface
- `PORTS`, 2: number of requesting input streams, ≥1.
- `BUF_SIZE`, 4: depth of upstream buffers; sets `packet_size` width to `$clog2(BUF_SIZE)+1`.
- `FULLPACKET`, 1: nonzero means eligibility requires `packet_size[i] != 0`; 0 means `flit_in[i].valid` alone suffices.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `packet_size`  in  `[PORTS][$clog2(BUF_SIZE):0]`  buffered complete-packet length per port; ignored when `FULLPACKET==0`.
- `flit_in`  in  `dii_flit [PORTS]`  upstream flits (valid, last, data).
- `flit_in_ready`  out  `[PORTS]`  per-port ready.
- `flit_out`  out  `dii_flit`  registered downstream flit.
- `flit_out_ready`  in  1  downstream ready.
- `grant_id`  out  `max(1,$clog2(PORTS))`  currently or last granted port.
- `busy`  out  1  high while a packet is locked.

## Operation
- Port request: `req[i] = flit_in[i].valid && (FULLPACKET==0 || packet_size[i]!=0)`.
- FSM with two states, IDLE and LOCKED. Reset state is IDLE.
- IDLE:
  - All `flit_in_ready` are 0.
  - If any `req` is set, select the first requesting index at or after `rr_ptr`, wrapping modulo `PORTS`.
  - Register the selection into `sel`/`grant_id` and go to LOCKED.
- LOCKED:
  - `flit_in_ready[sel] = !out_valid || flit_out_ready`; all other ready bits are 0.
  - On each input fire, `out_reg <= flit_in[sel]` and `out_valid <= 1`.
  - Otherwise, if `flit_out_ready`, `out_valid <= 0`.
  - `flit_out = {out_valid, out_reg.last, out_reg.data}`.
- Packet end: when a fire carries `last`, go to IDLE and set `rr_ptr <= (sel+1) mod PORTS`. `grant_id` holds its value.
- If `valid` drops mid-packet, stay LOCKED. No timeout.
- Single-flit packets are legal.
- With `PORTS==1`, the single port is always selected and `rr_ptr` stays 0.
- `req` is sampled only in IDLE. A `packet_size` change during LOCKED has no effect.
- Reset values: state IDLE, `rr_ptr` 0, `sel`/`grant_id` 0, `out_valid` 0 (so `flit_out.valid` 0), `busy` 0, all `flit_in_ready` 0.
- Reset mid-packet aborts the grant. Any remaining flits stay upstream, and the next grant forwards them as a new packet. Resetting upstream buffers and the arbiter together is the system's responsibility.

## Timing
- `req` seen in IDLE at cycle t → LOCKED and `busy` at t+1 → first input fire possible at t+1 → flit valid on `flit_out` at t+2.
- Steady state within a packet: 1 flit/cycle while `flit_out_ready` stays high. The output register gives a pass-through ready (no skid).
- `last` fires at cycle t → IDLE at t+1 → next grant LOCKED at t+2. This is one arbitration bubble per packet.
- `flit_out` holds stable while `valid && !flit_out_ready`.
- No combinational path from `flit_in` to `flit_out`. `flit_out_ready` reaches `flit_in_ready` combinationally.

## Structure
- `dii_flit` and `dii_flit_assemble` come from `dii_package`.
- Add an arbiter state enum (`ARB_IDLE`, `ARB_LOCKED`) to `dii_package` for reuse by later multi-port blocks.
- One natural sub-module: `dii_rr_select`, a combinational round-robin first-one finder (inputs `req`, `rr_ptr`; outputs `idx`, `any`).
- FSM, pointer and output register stay in this module.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → `flit_out.valid`, `busy` and all `flit_in_ready` go 0 immediately; `grant_id` is 0.
- Single port, `PORTS=2`: port 1 presents 3 flits with `packet_size=3` → `grant_id=1`, `busy` from t+1, flits on `flit_out` at t+2..t+4 with `last` on the third, IDLE afterward.
- Fairness: both ports continuously offer 2-flit packets → packets alternate 0,1,0,1. No flit interleaving; one bubble between packets.
- `FULLPACKET=1`: port 0 valid but `packet_size=0`, port 1 `packet_size=2` → port 1 is granted and port 0's ready stays 0 until its `packet_size` becomes nonzero.
- Backpressure: `flit_out_ready` low for 5 cycles mid-packet → `flit_out` stays stable, `flit_in_ready[sel]` is 0, and no flit is lost or duplicated. Data matches in order.
- Mid-packet reset: reset after 1 of 3 flits → IDLE. Remaining 2 flits are forwarded as a new grant once the port requests again.
